nonce_sweeper: RTL and testbench
================================

NONCE_SWEEPER -- requirements
Module: nonce_sweeper

Interface
REQ-001 Parameter NONCE_W, default 32, nonce and range width.
REQ-002 Parameter HASH_W, default 256, hash and target width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  begin sweep; sampled only in IDLE.
REQ-006 abort  input  1  terminate sweep; honoured in any state.
REQ-007 nonce_start  input  NONCE_W  first nonce; captured on accepted start.
REQ-008 nonce_end  input  NONCE_W  last nonce, inclusive; captured on accepted start.
REQ-009 target  input  HASH_W  difficulty target; captured on accepted start.
REQ-010 core_valid  output  1  nonce offered to hash core.
REQ-011 core_nonce  output  NONCE_W  nonce offered to hash core.
REQ-012 core_ready  input  1  hash core accepts nonce.
REQ-013 hash_valid  input  1  hash core result strobe.
REQ-014 hash_in  input  HASH_W  hash core result.
REQ-015 result_valid  output  1  winning nonce/hash available.
REQ-016 result_nonce  output  NONCE_W  winning nonce.
REQ-017 result_hash  output  HASH_W  winning hash.
REQ-018 result_ack  input  1  host consumes result.
REQ-019 busy  output  1  high in any state except IDLE.
REQ-020 found  output  1  sticky: at least one winner in current/last sweep.
REQ-021 done  output  1  one-cycle pulse on sweep completion.

Function
REQ-022 States SHALL be IDLE, ISSUE, WAIT, CHECK, REPORT, DONE; one nonce in flight at a time.
REQ-023 IDLE: start=1 and abort=0 -> capture start/end/target, cur<=nonce_start, clear found, go ISSUE next cycle.
REQ-024 ISSUE: core_valid=1, core_nonce=cur; on core_valid&&core_ready go WAIT; core_valid held until accepted.
REQ-025 WAIT: on hash_valid register hash_in, go CHECK; hash_valid in any other state ignored.
REQ-026 CHECK: hit iff registered hash <= captured target, unsigned HASH_W compare, equality is a hit.
REQ-027 CHECK hit -> REPORT with result_nonce=cur, result_hash=hash, result_valid=1, found=1.
REQ-028 CHECK miss: cur==end -> DONE; else cur<=cur+1 mod 2^NONCE_W, go ISSUE.
REQ-029 REPORT: hold result_valid and result_* stable until result_ack; then result_valid=0 and continue per REQ-028 (sweep finds all winners).
REQ-030 Wrap-around: nonce_end < nonce_start SHALL sweep through max value to 0 and stop after nonce_end.
REQ-031 nonce_start==nonce_end SHALL check exactly one nonce.
REQ-032 DONE: done=1 for exactly one cycle, then IDLE; found and result_nonce/result_hash retain values until next accepted start.
REQ-033 start while busy SHALL be ignored.
REQ-034 abort in any non-IDLE state -> IDLE next cycle; core_valid=0, result_valid=0, no done pulse; found retained.
REQ-035 abort and start same cycle in IDLE: abort wins, stays IDLE.
REQ-036 Latency: start to first core_valid = 1 cycle; hash_valid to result_valid or next core_valid = 2 cycles.

Reset
REQ-037 rst=1 SHALL force IDLE immediately, independent of clk.
REQ-038 Reset values: core_valid=0, core_nonce=0, result_valid=0, result_nonce=0, result_hash=0, busy=0, found=0, done=0.
REQ-039 Reset mid-sweep SHALL discard in-flight nonce; later hash_valid ignored.

Verification
REQ-040 start=1, nonce_start=10, nonce_end=12, target=all ones, ack each -> three results nonces 10,11,12, found=1, one done.
REQ-041 target=0, hashes nonzero, range 5..7 -> core_nonce 5,6,7 issued, no result_valid, done pulse, found=0.
REQ-042 range 0xFFFFFFFE..0x00000001, all miss -> core_nonce sequence FFFFFFFE, FFFFFFFF, 0, 1, then done.
REQ-043 hash_in==target exactly -> hit; result_hash equals target; hash=target+1 -> miss.
REQ-044 core_ready held 0 for 5 cycles -> core_valid and core_nonce stable; result_ack delayed 3 cycles -> result_* stable.
REQ-045 abort during WAIT, then stray hash_valid -> IDLE, no done, no result; rst asserted mid-ISSUE -> all outputs zero asynchronously.

Source files
------------

// File: rtl/nonce_sweeper_if.sv
// nonce_sweeper_if: host control, hash-core and result handshakes for nonce_sweeper
interface nonce_sweeper_if #(
  parameter int NONCE_W = 32,
  parameter int HASH_W  = 256
);
  logic               start;
  logic               abort;
  logic [NONCE_W-1:0] nonce_start;
  logic [NONCE_W-1:0] nonce_end;
  logic [HASH_W-1:0]  target;
  logic               core_valid;
  logic [NONCE_W-1:0] core_nonce;
  logic               core_ready;
  logic               hash_valid;
  logic [HASH_W-1:0]  hash_in;
  logic               result_valid;
  logic [NONCE_W-1:0] result_nonce;
  logic [HASH_W-1:0]  result_hash;
  logic               result_ack;
  logic               busy;
  logic               found;
  logic               done;
  modport master (
    output start, abort, nonce_start, nonce_end, target, core_ready, hash_valid, hash_in, result_ack,
    input  core_valid, core_nonce, result_valid, result_nonce, result_hash, busy, found, done
  );
  modport slave (
    input  start, abort, nonce_start, nonce_end, target, core_ready, hash_valid, hash_in, result_ack,
    output core_valid, core_nonce, result_valid, result_nonce, result_hash, busy, found, done
  );
endinterface

// File: rtl/nonce_sweeper.sv
// nonce_sweeper: sweeps a nonce range through a hash core and reports every hash <= target
module nonce_sweeper #(
  parameter int NONCE_W = 32,
  parameter int HASH_W  = 256
) (
  input logic            clk,
  input logic            rst,
  nonce_sweeper_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, REPORT, DONE} state_t;
  state_t             state;
  logic [NONCE_W-1:0] cur;
  logic [NONCE_W-1:0] last;
  logic [NONCE_W-1:0] nxt;
  logic [HASH_W-1:0]  tgt;
  logic [HASH_W-1:0]  hash;
  logic               at_end;
  always_comb begin
    nxt    = cur + 1'b1;
    at_end = cur == last;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cur              <= '0;
      last             <= '0;
      tgt              <= '0;
      hash             <= '0;
      bus.core_valid   <= 1'b0;
      bus.core_nonce   <= '0;
      bus.result_valid <= 1'b0;
      bus.result_nonce <= '0;
      bus.result_hash  <= '0;
      bus.busy         <= 1'b0;
      bus.found        <= 1'b0;
      bus.done         <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state != IDLE && bus.abort) begin
        state            <= IDLE;
        bus.core_valid   <= 1'b0;
        bus.result_valid <= 1'b0;
        bus.busy         <= 1'b0;
      end else begin
        case (state)
          IDLE: if (bus.start && !bus.abort) begin
            state          <= ISSUE;
            cur            <= bus.nonce_start;
            last           <= bus.nonce_end;
            tgt            <= bus.target;
            bus.found      <= 1'b0;
            bus.busy       <= 1'b1;
            bus.core_valid <= 1'b1;
            bus.core_nonce <= bus.nonce_start;
          end
          ISSUE: if (bus.core_ready) begin
            state          <= WAIT;
            bus.core_valid <= 1'b0;
          end
          WAIT: if (bus.hash_valid) begin
            state <= CHECK;
            hash  <= bus.hash_in;
          end
          CHECK: if (hash <= tgt) begin
            state            <= REPORT;
            bus.result_valid <= 1'b1;
            bus.result_nonce <= cur;
            bus.result_hash  <= hash;
            bus.found        <= 1'b1;
          end else if (at_end) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end else begin
            state          <= ISSUE;
            cur            <= nxt;
            bus.core_valid <= 1'b1;
            bus.core_nonce <= nxt;
          end
          REPORT: if (bus.result_ack) begin
            bus.result_valid <= 1'b0;
            state            <= at_end ? DONE : ISSUE;
            bus.done         <= at_end;
            bus.core_valid   <= !at_end;
            cur              <= at_end ? cur : nxt;
            bus.core_nonce   <= at_end ? bus.core_nonce : nxt;
          end
          DONE: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_nonce_sweeper.sv
// tb_nonce_sweeper: directed checks of range sweep, hit/miss compare, stalls, abort and reset
module tb_nonce_sweeper;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  localparam logic [255:0] ONES = '1;
  localparam logic [255:0] T    = 256'h100;
  nonce_sweeper_if bus ();
  nonce_sweeper dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic go(input logic [31:0] a, input logic [31:0] b, input logic [255:0] t);
    bus.nonce_start = a;
    bus.nonce_end   = b;
    bus.target      = t;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("busy_after_start", 256'(bus.busy), 256'd1);
    chk("cv_after_start", 256'(bus.core_valid), 256'd1);
    chk("found_cleared", 256'(bus.found), 256'd0);
  endtask

  task automatic serve(input logic [31:0] n, input logic [255:0] h);
    int k = 0;
    while (!bus.core_valid && k < 20) begin
      tick();
      k++;
    end
    chk("core_valid", 256'(bus.core_valid), 256'd1);
    chk("core_nonce", 256'(bus.core_nonce), 256'(n));
    bus.core_ready = 1'b1;
    tick();
    bus.core_ready = 1'b0;
    bus.hash_in    = h;
    bus.hash_valid = 1'b1;
    tick();
    bus.hash_valid = 1'b0;
  endtask

  task automatic hit(input logic [31:0] n, input logic [255:0] h, input int d);
    serve(n, h);
    tick();
    chk("result_valid", 256'(bus.result_valid), 256'd1);
    chk("result_nonce", 256'(bus.result_nonce), 256'(n));
    chk("result_hash", bus.result_hash, h);
    chk("found_on_hit", 256'(bus.found), 256'd1);
    for (int i = 0; i < d; i++) begin
      tick();
      chk("rv_hold", 256'(bus.result_valid), 256'd1);
      chk("rnonce_hold", 256'(bus.result_nonce), 256'(n));
      chk("rhash_hold", bus.result_hash, h);
    end
    bus.result_ack = 1'b1;
    tick();
    bus.result_ack = 1'b0;
    chk("rv_clear", 256'(bus.result_valid), 256'd0);
  endtask

  task automatic miss(input logic [31:0] n, input logic [255:0] h, input logic last);
    serve(n, h);
    tick();
    chk("rv_on_miss", 256'(bus.result_valid), 256'd0);
    if (last) chk("done_after_last", 256'(bus.done), 256'd1);
    else chk("cv_after_miss", 256'(bus.core_valid), 256'd1);
  endtask

  task automatic fin(input logic fnd);
    chk("done", 256'(bus.done), 256'd1);
    chk("found_end", 256'(bus.found), 256'(fnd));
    tick();
    chk("done_pulse", 256'(bus.done), 256'd0);
    chk("busy_end", 256'(bus.busy), 256'd0);
    chk("found_kept", 256'(bus.found), 256'(fnd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.nonce_start = '0; bus.nonce_end = '0;
    bus.target = '0; bus.core_ready = 1'b0; bus.hash_valid = 1'b0; bus.hash_in = '0;
    bus.result_ack = 1'b0;
    tick();
    chk("rst_core_valid", 256'(bus.core_valid), 256'd0);
    chk("rst_core_nonce", 256'(bus.core_nonce), 256'd0);
    chk("rst_result_valid", 256'(bus.result_valid), 256'd0);
    chk("rst_result_nonce", 256'(bus.result_nonce), 256'd0);
    chk("rst_result_hash", bus.result_hash, 256'd0);
    chk("rst_busy", 256'(bus.busy), 256'd0);
    chk("rst_found", 256'(bus.found), 256'd0);
    chk("rst_done", 256'(bus.done), 256'd0);
    rst = 1'b0;
    tick();
    // all winners in 10..12
    go(10, 12, ONES);
    hit(10, 256'h1234, 0);
    hit(11, 256'h5678, 0);
    hit(12, 256'h9abc, 0);
    fin(1'b1);
    // all misses in 5..7
    go(5, 7, 256'd0);
    miss(5, 256'd1, 1'b0);
    miss(6, 256'd2, 1'b0);
    miss(7, 256'd3, 1'b1);
    fin(1'b0);
    // wrap-around through max
    go(32'hFFFF_FFFE, 32'h1, 256'd0);
    miss(32'hFFFF_FFFE, 256'd1, 1'b0);
    miss(32'hFFFF_FFFF, 256'd1, 1'b0);
    miss(32'h0, 256'd1, 1'b0);
    miss(32'h1, 256'd1, 1'b1);
    fin(1'b0);
    // equality hits, one above misses
    go(20, 21, T);
    hit(20, T, 0);
    miss(21, T + 256'd1, 1'b1);
    fin(1'b1);
    // single nonce, core stall and delayed ack
    go(40, 40, ONES);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_cv", 256'(bus.core_valid), 256'd1);
      chk("stall_nonce", 256'(bus.core_nonce), 256'd40);
    end
    hit(40, 256'h77, 3);
    fin(1'b1);
    // start while busy, abort in WAIT, stray hash
    go(50, 55, ONES);
    bus.nonce_start = 99;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_busy_ignored", 256'(bus.core_nonce), 256'd50);
    bus.core_ready = 1'b1;
    tick();
    bus.core_ready = 1'b0;
    chk("cv_in_wait", 256'(bus.core_valid), 256'd0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", 256'(bus.busy), 256'd0);
    chk("abort_done", 256'(bus.done), 256'd0);
    bus.hash_in = '0;
    bus.hash_valid = 1'b1;
    tick();
    bus.hash_valid = 1'b0;
    tick();
    chk("stray_rv", 256'(bus.result_valid), 256'd0);
    chk("stray_busy", 256'(bus.busy), 256'd0);
    chk("stray_done", 256'(bus.done), 256'd0);
    chk("stray_cv", 256'(bus.core_valid), 256'd0);
    chk("abort_result_kept", 256'(bus.result_nonce), 256'd40);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("abort_wins", 256'(bus.busy), 256'd0);
    // asynchronous reset mid-ISSUE
    go(60, 61, ONES);
    #2 rst = 1'b1;
    #1;
    chk("arst_core_valid", 256'(bus.core_valid), 256'd0);
    chk("arst_core_nonce", 256'(bus.core_nonce), 256'd0);
    chk("arst_busy", 256'(bus.busy), 256'd0);
    chk("arst_result_nonce", 256'(bus.result_nonce), 256'd0);
    chk("arst_result_hash", bus.result_hash, 256'd0);
    chk("arst_result_valid", 256'(bus.result_valid), 256'd0);
    tick();
    rst = 1'b0;
    bus.hash_valid = 1'b1;
    tick();
    bus.hash_valid = 1'b0;
    tick();
    chk("post_rst_rv", 256'(bus.result_valid), 256'd0);
    chk("post_rst_busy", 256'(bus.busy), 256'd0);
    chk("post_rst_found", 256'(bus.found), 256'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
